div: RTL and testbench

Sequential sign-magnitude divider, the inverse companion of the team's shift-and-add multiplier. It divides a 16-bit sign-magnitude dividend (the multiplier's product format) by an 8-bit sign-magnitude divisor (the multiplier's operand format). It produces a 16-bit quotient and an 8-bit remainder using restoring division, one quotient bit per clock. It uses the same start/busy handshake as the multiplier, so both can sit side by side in the arithmetic unit.

---
 rtl/div.sv | 130 +++++++++++++
 tb/tb_div.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Sequential sign-magnitude restoring divider: 16-bit dividend / 8-bit divisor,
// one quotient bit per clock, start/busy handshake shared with the multiplier.
module div (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] a_bi,
  input  logic [7:0]  b_bi,
  input  logic        start_i,
  output logic        busy_o,
  output logic [15:0] q_bo,
  output logic [7:0]  r_bo,
  output logic        dbz_o
);

  typedef enum logic {IDLE, WORK} state_t;

  state_t      state, state_nx;
  logic        sign_a, sign_b;
  logic [14:0] a_mag;
  logic [6:0]  b_mag;
  logic [7:0]  rem;
  logic [14:0] quo;
  logic [3:0]  ctr;

  logic        accept, dbz_hit, last;
  logic [3:0]  bit_idx;
  logic [7:0]  rem_sh, rem_nx;
  logic        q_bit;
  logic [14:0] quo_nx;
  logic        qsign, rsign;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    dbz_hit  = 1'b0;
    last     = 1'b0;

    // The quotient is built MSB first, so shifting the new bit in from the
    // right lands it on position 14 - ctr after all 15 steps.
    bit_idx = 4'd14 - ctr;
    rem_sh  = {rem[6:0], a_mag[bit_idx]};
    q_bit   = (rem_sh >= {1'b0, b_mag});
    rem_nx  = q_bit ? (rem_sh - {1'b0, b_mag}) : rem_sh;
    quo_nx  = {quo[13:0], q_bit};

    // Zero magnitudes always carry a + sign.
    qsign = (sign_a ^ sign_b) & (|quo_nx);
    rsign = sign_a & (|rem_nx[6:0]);

    case (state)
      IDLE: begin
        if (start_i) begin
          if (|b_bi[6:0]) begin
            accept   = 1'b1;
            state_nx = WORK;
          end else begin
            dbz_hit = 1'b1;
          end
        end
      end
      WORK: begin
        if (ctr == 4'd14) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: all registers, including the operand latches, are reset so an aborted
  // division leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      rem    <= '0;
      quo    <= '0;
      ctr    <= '0;
      busy_o <= 1'b0;
      q_bo   <= '0;
      r_bo   <= '0;
      dbz_o  <= 1'b0;
    end else begin
      if (accept) begin
        sign_a <= a_bi[15];
        a_mag  <= a_bi[14:0];
        sign_b <= b_bi[7];
        b_mag  <= b_bi[6:0];
        rem    <= '0;
        quo    <= '0;
        ctr    <= '0;
        busy_o <= 1'b1;
      end

      if (dbz_hit) begin
        q_bo  <= {a_bi[15] ^ b_bi[7], 15'h7FFF};
        r_bo  <= '0;
        dbz_o <= 1'b1;
      end

      if (state == WORK) begin
        rem <= rem_nx;
        quo <= quo_nx;
        ctr <= ctr + 4'd1;
      end

      if (last) begin
        q_bo   <= {qsign, quo_nx};
        r_bo   <= {rsign, rem_nx[6:0]};
        dbz_o  <= 1'b0;
        busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus randomized operands checked
// against an arithmetic reference model (integer / and %).
module tb_div;

  logic        clk_i;
  logic        rst_ni;
  logic [15:0] a_bi;
  logic [7:0]  b_bi;
  logic        start_i;
  logic        busy_o;
  logic [15:0] q_bo;
  logic [7:0]  r_bo;
  logic        dbz_o;

  int n_checks = 0;
  int n_pass   = 0;

  div dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .a_bi   (a_bi),
    .b_bi   (b_bi),
    .start_i(start_i),
    .busy_o (busy_o),
    .q_bo   (q_bo),
    .r_bo   (r_bo),
    .dbz_o  (dbz_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer division on magnitudes, sign rules applied after.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] eq, output logic [7:0] er, output logic ed);
    int unsigned am, bm, qm, rm;
    logic sa, sb;
    am = a[14:0];
    bm = b[6:0];
    sa = a[15];
    sb = b[7];
    if (bm == 0) begin
      eq = {sa ^ sb, 15'h7FFF};
      er = 8'h00;
      ed = 1'b1;
    end else begin
      qm = am / bm;
      rm = am % bm;
      eq = {(sa ^ sb) && (qm != 0), 15'(qm)};
      er = {sa && (rm != 0), 7'(rm)};
      ed = 1'b0;
    end
  endtask

  // Issues one operation and checks latency and result against the model.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input string tag);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    int          cyc;
    model(a, b, eq, er, ed);
    @(negedge clk_i);
    a_bi    = a;
    b_bi    = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    a_bi    = 16'($urandom);
    b_bi    = 8'($urandom);
    if (ed) begin
      check({tag, "_dbz_busy"}, 32'(busy_o), 32'd0);
    end else begin
      check({tag, "_busy_up"}, 32'(busy_o), 32'd1);
      cyc = 0;
      while (busy_o && cyc < 40) begin
        @(posedge clk_i);
        #1;
        cyc++;
      end
      check({tag, "_cycles"}, 32'(cyc), 32'd15);
    end
    check({tag, "_q"}, 32'(q_bo), 32'(eq));
    check({tag, "_r"}, 32'(r_bo), 32'(er));
    check({tag, "_dbz"}, 32'(dbz_o), 32'(ed));
  endtask

  initial begin
    int cyc;
    logic [15:0] ra;
    logic [7:0]  rb;

    rst_ni  = 1'b0;
    start_i = 1'b0;
    a_bi    = '0;
    b_bi    = '0;
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_q", 32'(q_bo), 32'd0);
    check("rst_r", 32'(r_bo), 32'd0);
    check("rst_dbz", 32'(dbz_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    do_div(16'h03E8, 8'h07, "d1000_7");
    check("plan_q1", 32'(q_bo), 32'h008E);
    check("plan_r1", 32'(r_bo), 32'h06);
    do_div(16'h83E8, 8'h07, "neg_a");
    check("plan_q2", 32'(q_bo), 32'h808E);
    check("plan_r2", 32'(r_bo), 32'h86);
    do_div(16'h03E8, 8'h87, "neg_b");
    check("plan_q3", 32'(q_bo), 32'h808E);
    check("plan_r3", 32'(r_bo), 32'h06);
    do_div(16'h7FFF, 8'h01, "max_q");
    check("plan_q4", 32'(q_bo), 32'h7FFF);
    do_div(16'h0005, 8'h7F, "small_a");
    check("plan_r5", 32'(r_bo), 32'h05);
    do_div(16'h8003, 8'h07, "zero_q");
    check("plan_q6", 32'(q_bo), 32'h0000);
    check("plan_r6", 32'(r_bo), 32'h83);
    do_div(16'h8000, 8'h85, "zero_both");
    check("plan_r7", 32'(r_bo), 32'h00);
    do_div(16'h0005, 8'h80, "dbz");
    check("plan_q8", 32'(q_bo), 32'hFFFF);
    do_div(16'h000A, 8'h02, "after_dbz");
    check("plan_q9", 32'(q_bo), 32'h0005);

    // start pulsed mid-operation with different operands is ignored
    @(negedge clk_i);
    a_bi    = 16'h1234;
    b_bi    = 8'h0B;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    cyc = 0;
    while (busy_o && cyc < 40) begin
      if (cyc == 6) begin
        @(negedge clk_i);
        a_bi    = 16'h0FFF;
        b_bi    = 8'h03;
        start_i = 1'b1;
      end
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      cyc++;
    end
    check("ign_cycles", 32'(cyc), 32'd15);
    check("ign_q", 32'(q_bo), 32'(16'h1234 / 16'h000B));
    check("ign_r", 32'(r_bo), 32'(16'h1234 % 16'h000B));

    // asynchronous reset mid-operation
    @(negedge clk_i);
    a_bi    = 16'h4321;
    b_bi    = 8'h05;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_q", 32'(q_bo), 32'd0);
    check("arst_r", 32'(r_bo), 32'd0);
    check("arst_dbz", 32'(dbz_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_div(16'h0064, 8'h09, "post_rst");

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) rb[6:0] = 7'd0;
      do_div(ra, rb, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
